// File: rtl/alu_pkg.sv
// Shared opcode encodings (MIPS R-type funct field) for the registered ALU.
// Optional status flags are enabled by defining ALU_FLAGS_EN.
package alu_pkg;

  localparam int OP_LENGTH = 6;

  localparam logic [OP_LENGTH-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_LENGTH-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_LENGTH-1:0] OP_AND = 6'b100100;
  localparam logic [OP_LENGTH-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_LENGTH-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_LENGTH-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_LENGTH-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_LENGTH-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus, with ALU_FLAGS_EN defined,
// zero / carry-borrow / signed-overflow flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_LENGTH = 8
) (
  input  logic        [OP_LENGTH-1:0]   op_i,
  input  logic signed [DATA_LENGTH-1:0] a_i,
  input  logic signed [DATA_LENGTH-1:0] b_i,
  output logic signed [DATA_LENGTH-1:0] res_o
`ifdef ALU_FLAGS_EN
  ,
  output logic                          zero_o,
  output logic                          carry_o,
  output logic                          ovf_o
`endif
);

  localparam int MSB = DATA_LENGTH - 1;

  // B is always an unsigned shift count; counts >= width saturate naturally
  logic [DATA_LENGTH-1:0] shamt;
  assign shamt = $unsigned(b_i);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_SRA:  res_o = a_i >>> shamt;
      OP_SRL:  res_o = a_i >> shamt;
      default: res_o = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        // carry out of the MSB recovered from the MSB bits and the sum bit
        carry_o = (a_i[MSB] & b_i[MSB]) | ((a_i[MSB] | b_i[MSB]) & ~res_o[MSB]);
        ovf_o   = (a_i[MSB] == b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        carry_o = ($unsigned(a_i) < $unsigned(b_i));
        ovf_o   = (a_i[MSB] != b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
      end
      default: begin
        carry_o = 1'b0;
        ovf_o   = 1'b0;
      end
    endcase
  end

  assign zero_o = (res_o == '0);
`endif

endmodule

// File: rtl/alu_reg.sv
// Registered ALU: one-cycle latency, result holds while i_valid is low.
// Define ALU_FLAGS_EN to add registered o_zero / o_carry / o_overflow outputs.
module alu_reg
  import alu_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int OP_LENGTH   = alu_pkg::OP_LENGTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic        [OP_LENGTH-1:0]   Op_code,
  input  logic signed [DATA_LENGTH-1:0] A,
  input  logic signed [DATA_LENGTH-1:0] B,
  output logic signed [DATA_LENGTH-1:0] Resultado,
  output logic                          o_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic                          o_zero,
  output logic                          o_carry,
  output logic                          o_overflow
`endif
);

  logic signed [DATA_LENGTH-1:0] res_d, res_q;
  logic                          vld_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, carry_d, ovf_d;
  logic zero_q, carry_q, ovf_q;
`endif

  alu_core #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_core (
    .op_i    (Op_code),
    .a_i     (A),
    .b_i     (B),
    .res_o   (res_d)
`ifdef ALU_FLAGS_EN
    ,
    .zero_o  (zero_d),
    .carry_o (carry_d),
    .ovf_o   (ovf_d)
`endif
  );

  // Output stage: capture on valid, otherwise hold; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= i_valid;
      if (i_valid) begin
        res_q <= res_d;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_valid) begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
`endif

  assign Resultado = res_q;
  assign o_valid   = vld_q;

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg (DATA_LENGTH=8): vector table, hand-written
// reset/back-to-back/hold sequences and a random sweep against a reference model.
module tb_alu_reg;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic [5:0]        Op_code;
  logic signed [7:0] A;
  logic signed [7:0] B;
  logic signed [7:0] Resultado;
  logic              o_valid;
`ifdef ALU_FLAGS_EN
  logic              o_zero, o_carry, o_overflow;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t last_e;
  vec_t vt[18];

  always #5 clk = ~clk;

  alu_reg #(
    .DATA_LENGTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .Op_code    (Op_code),
    .A          (A),
    .B          (B),
    .Resultado  (Resultado),
    .o_valid    (o_valid)
`ifdef ALU_FLAGS_EN
    ,
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
`endif
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int   sa, sb_i, s, n;
    r  = '{8'h00, 1'b0, 1'b0, 1'b0};
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    case (op)
      6'b100000: begin
        r.res = a + b;
        r.c   = ((int'(a) + int'(b)) > 255);
        s     = sa + sb_i;
        r.v   = (s > 127) || (s < -128);
      end
      6'b100010: begin
        r.res = a - b;
        r.c   = (a < b);
        s     = sa - sb_i;
        r.v   = (s > 127) || (s < -128);
      end
      6'b100100: r.res = a & b;
      6'b100101: r.res = a | b;
      6'b100110: r.res = a ^ b;
      6'b100111: r.res = ~(a | b);
      6'b000011, 6'b000010: begin
        r.res = a;
        n = (int'(b) > 8) ? 8 : int'(b);
        for (int i = 0; i < n; i++)
          r.res = {(op == 6'b000011) ? a[7] : 1'b0, r.res[7:1]};
      end
      default: r.res = 8'h00;
    endcase
    r.z = (r.res == 8'h00);
    return r;
  endfunction

  // One clock: drive at negedge, push expectation, check #1 after posedge.
  task automatic drive(input string tag, input logic r, input logic v,
                       input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r; i_valid = v; Op_code = op; A = a; B = b;
    if (v && !r) sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) last_e = '{8'h00, 1'b0, 1'b0, 1'b0};
    cmp($sformatf("%s.o_valid", tag), {63'd0, o_valid}, {63'd0, (v && !r)});
    if (o_valid) begin
      if (sb.size() == 0) begin
        cmp($sformatf("%s.scoreboard_nonempty", tag), 64'd0, 64'd1);
      end else begin
        got    = sb.pop_front();
        last_e = got;
      end
    end
    cmp($sformatf("%s.Resultado", tag), {56'd0, Resultado}, {56'd0, last_e.res});
`ifdef ALU_FLAGS_EN
    cmp($sformatf("%s.o_zero", tag),     {63'd0, o_zero},     {63'd0, last_e.z});
    cmp($sformatf("%s.o_carry", tag),    {63'd0, o_carry},    {63'd0, last_e.c});
    cmp($sformatf("%s.o_overflow", tag), {63'd0, o_overflow}, {63'd0, last_e.v});
`endif
  endtask

  initial begin
    exp_t       e;
    logic [5:0] op;
    logic [7:0] a, b;
    logic       v;
    logic [5:0] ops[10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b000011, 6'b000010, 6'b111111, 6'b000000};

    vt[0]  = '{6'b100000, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1}};
    vt[1]  = '{6'b100010, 8'h00, 8'h01, '{8'hFF, 1'b0, 1'b1, 1'b0}};
    vt[2]  = '{6'b100100, 8'h0F, 8'h3C, '{8'h0C, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{6'b100101, 8'h0F, 8'h3C, '{8'h3F, 1'b0, 1'b0, 1'b0}};
    vt[4]  = '{6'b100110, 8'h0F, 8'h3C, '{8'h33, 1'b0, 1'b0, 1'b0}};
    vt[5]  = '{6'b100111, 8'h0F, 8'h3C, '{8'hC0, 1'b0, 1'b0, 1'b0}};
    vt[6]  = '{6'b100111, 8'h0F, 8'hF0, '{8'h00, 1'b1, 1'b0, 1'b0}};
    vt[7]  = '{6'b000011, 8'h80, 8'h02, '{8'hE0, 1'b0, 1'b0, 1'b0}};
    vt[8]  = '{6'b000010, 8'h80, 8'h02, '{8'h20, 1'b0, 1'b0, 1'b0}};
    vt[9]  = '{6'b000011, 8'h80, 8'h09, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    vt[10] = '{6'b000010, 8'h80, 8'h09, '{8'h00, 1'b1, 1'b0, 1'b0}};
    vt[11] = '{6'b000011, 8'h80, 8'h80, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    vt[12] = '{6'b000010, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b0, 1'b0}};
    vt[13] = '{6'b111111, 8'h55, 8'hAA, '{8'h00, 1'b1, 1'b0, 1'b0}};
    vt[14] = '{6'b000011, 8'h80, 8'h00, '{8'h80, 1'b0, 1'b0, 1'b0}};
    vt[15] = '{6'b000010, 8'h5A, 8'h00, '{8'h5A, 1'b0, 1'b0, 1'b0}};
    vt[16] = '{6'b100000, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0}};
    vt[17] = '{6'b100010, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b1}};

    rst = 1'b1; i_valid = 1'b0; Op_code = '0; A = '0; B = '0;
    last_e = '{8'h00, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);

    // reset wins over a valid ADD, then the same ADD goes through
    drive("reset_add", 1'b1, 1'b1, 6'b100000, 8'h05, 8'h03, '{8'h00, 1'b0, 1'b0, 1'b0});
    drive("add_5_3",   1'b0, 1'b1, 6'b100000, 8'h05, 8'h03, '{8'h08, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 18; i++)
      drive($sformatf("vec%0d", i), 1'b0, 1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].e);

    // back-to-back ADD then SUB, then idle cycles must hold the SUB result
    drive("b2b_add", 1'b0, 1'b1, 6'b100000, 8'h10, 8'h22, '{8'h32, 1'b0, 1'b0, 1'b0});
    drive("b2b_sub", 1'b0, 1'b1, 6'b100010, 8'h10, 8'h22, '{8'hEE, 1'b0, 1'b1, 1'b0});
    drive("hold1",   1'b0, 1'b0, 6'b100000, 8'h01, 8'h01, '{8'h00, 1'b0, 1'b0, 1'b0});
    drive("hold2",   1'b0, 1'b0, 6'b100101, 8'hFF, 8'h00, '{8'h00, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      v  = ($urandom_range(0, 4) != 0);
      drive($sformatf("rand%0d", i), 1'b0, v, op, a, b, ref_model(op, a, b));
    end

    // a mid-run reset clears result and valid
    drive("reset_mid", 1'b1, 1'b1, 6'b100101, 8'hF0, 8'h0F, '{8'h00, 1'b0, 1'b0, 1'b0});
    drive("idle_after_reset", 1'b0, 1'b0, 6'b100101, 8'hF0, 8'h0F, '{8'h00, 1'b0, 1'b0, 1'b0});

    cmp("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
